// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: data width,
// funct3 op encodings and the FSM state encoding.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // funct3[2] separates the divide family from the multiply family
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign correction and output-word selection. The iterative
// datapath works on magnitudes only; this block restores signs and applies
// the RV32M divide-by-zero and signed-overflow results.
module muldiv_signfix
  import riscv_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,       // product, or {remainder, quotient}
  input  logic [2:0]        op,
  input  logic              neg_a,     // operand a was negative and signed
  input  logic              neg_b,     // operand b was negative and signed
  input  logic              div_zero,  // divisor was zero
  input  logic              div_ovf,   // signed 0x80000000 / -1
  input  logic [XLEN-1:0]   orig_a,    // untouched dividend, for REM by zero
  output logic [XLEN-1:0]   res
);

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // Negate magnitudes back to signed results, then pick the word for op
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;
    quo_fix  = (neg_a ^ neg_b) ? (~acc[XLEN-1:0] + 32'd1) : acc[XLEN-1:0];
    // remainder follows the sign of the dividend
    rem_fix  = neg_a ? (~acc[2*XLEN-1:XLEN] + 32'd1) : acc[2*XLEN-1:XLEN];
    res      = '0;
    case (op)
      OP_MUL:                       res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero)     res = '1;
        else if (div_ovf) res = 32'h8000_0000;
        else              res = quo_fix;
      end
      default: begin
        if (div_zero)     res = orig_a;
        else if (div_ovf) res = '0;
        else              res = rem_fix;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Fixed 33-edge latency from
// acceptance to done: one capture edge, 32 iteration edges, then a final
// edge that registers the sign-corrected result.
//
// Handshake: a request is accepted on a rising edge where start=1, flush=0
// and busy=0. busy stays high until the unit is back in IDLE; a start seen
// while busy is dropped, not queued. done is a one-cycle pulse and result /
// rd_out are valid while it is high (and hold until the next completion).
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,        // asynchronous, active low
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic [1:0]      dbg_state
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;      // mul: product; div: {rem, quo}
  logic [XLEN-1:0]   b_q, b_d;          // multiplicand / divisor magnitude
  logic [XLEN-1:0]   orig_a_q, orig_a_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              done_q, done_d;

  logic              accept;
  logic              a_signed, b_signed;
  logic              in_neg_a, in_neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   fix_res;

  assign accept = (state_q == ST_IDLE) && start && !flush;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; flush from CALC or FIN drops straight back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CALC;
      ST_CALC: begin
        if (flush)                                 state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))        state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM-derived outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = done_q;
    result    = result_q;
    rd_out    = rd_out_q;
    dbg_state = state_q;
  end

  // Operand decode at capture: signedness per op and magnitudes
  always_comb begin
    a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    in_neg_a = a_signed && operand_a[XLEN-1];
    in_neg_b = b_signed && operand_b[XLEN-1];
    mag_a    = in_neg_a ? (~operand_a + 32'd1) : operand_a;
    mag_b    = in_neg_b ? (~operand_b + 32'd1) : operand_b;
  end

  // One iteration: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q})
                         : {1'b0, acc_q[2*XLEN-1:XLEN]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    if (is_div(op_q)) begin
      if (!div_diff[XLEN])
        acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  muldiv_signfix u_signfix (
    .acc      (acc_q),
    .op       (op_q),
    .neg_a    (neg_a_q),
    .neg_b    (neg_b_q),
    .div_zero (dz_q),
    .div_ovf  (ovf_q),
    .orig_a   (orig_a_q),
    .res      (fix_res)
  );

  // Datapath next values: capture in IDLE, iterate in CALC, publish in FIN
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    b_d      = b_q;
    orig_a_d = orig_a_q;
    rd_d     = rd_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          op_d     = op;
          acc_d    = {{XLEN{1'b0}}, mag_a};
          b_d      = mag_b;
          orig_a_d = operand_a;
          rd_d     = rd_in;
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          dz_d     = (operand_b == '0);
          ovf_d    = ((op == OP_DIV) || (op == OP_REM)) &&
                     (operand_a == 32'h8000_0000) && (operand_b == '1);
        end
      end
      ST_CALC: begin
        if (!flush) begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        if (!flush) begin
          result_d = fix_res;
          rd_out_d = rd_q;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      orig_a_q <= '0;
      rd_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      orig_a_q <= orig_a_d;
      rd_q     <= rd_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, randomized ops checked
// against an arithmetic reference model, start-while-busy, flush and
// asynchronous reset scenarios.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: RV32M semantics straight from 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                            input logic [31:0] y);
    longint     sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    p  = 64'd0;
    case (f)
      OP_MUL:    begin p = sx * sy; return p[31:0];  end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * uy; return p[63:32]; end
      OP_MULHU:  begin p = ux * uy; return p[63:32]; end
      OP_DIV: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      OP_DIVU: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        p = ux / uy; return p[31:0];
      end
      OP_REM: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 32'd0) return x;
        p = ux % uy; return p[31:0];
      end
    endcase
  endfunction

  // driver: present a request before an edge; returns 1ns after acceptance edge
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r);
    @(negedge clk);
    op = f; operand_a = x; operand_b = y; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Wait for done, k0 edges already elapsed since acceptance
  task automatic wait_done(input string tag, input int k0, input logic [4:0] exp_rd);
    int k;
    int busy_drop;
    logic [31:0] exp_v;
    k = k0;
    busy_drop = 0;
    while (k < 60) begin
      @(posedge clk); #1;
      k++;
      if (done) break;
      if (!busy) busy_drop++;
    end
    exp_v = exp_q.pop_front();
    if (!done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, 32'(k), 32'd33);
      check({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
      check({tag, "_result"}, result, exp_v);
      check({tag, "_rd"}, {27'd0, rd_out}, {27'd0, exp_rd});
      check({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
      last_result = exp_v;
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_result_hold"}, result, exp_v);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input logic [31:0] exp_v);
    exp_q.push_back(exp_v);
    issue(f, x, y, r);
    wait_done(tag, 0, r);
  endtask

  // directed stimulus table
  logic [2:0]  d_op [14];
  logic [31:0] d_a  [14];
  logic [31:0] d_b  [14];
  logic [31:0] d_e  [14];

  initial begin
    d_op[0]  = OP_MUL;    d_a[0]  = 32'd7;          d_b[0]  = 32'hFFFF_FFFD; d_e[0]  = 32'hFFFF_FFEB;
    d_op[1]  = OP_MULH;   d_a[1]  = 32'h8000_0000;  d_b[1]  = 32'h8000_0000; d_e[1]  = 32'h4000_0000;
    d_op[2]  = OP_MULHU;  d_a[2]  = 32'hFFFF_FFFF;  d_b[2]  = 32'hFFFF_FFFF; d_e[2]  = 32'hFFFF_FFFE;
    d_op[3]  = OP_MULHSU; d_a[3]  = 32'hFFFF_FFFF;  d_b[3]  = 32'hFFFF_FFFF; d_e[3]  = 32'hFFFF_FFFF;
    d_op[4]  = OP_DIV;    d_a[4]  = 32'hFFFF_FFF9;  d_b[4]  = 32'd2;         d_e[4]  = 32'hFFFF_FFFD;
    d_op[5]  = OP_REM;    d_a[5]  = 32'hFFFF_FFF9;  d_b[5]  = 32'd2;         d_e[5]  = 32'hFFFF_FFFF;
    d_op[6]  = OP_DIVU;   d_a[6]  = 32'd100;        d_b[6]  = 32'd7;         d_e[6]  = 32'd14;
    d_op[7]  = OP_REMU;   d_a[7]  = 32'd100;        d_b[7]  = 32'd7;         d_e[7]  = 32'd2;
    d_op[8]  = OP_DIV;    d_a[8]  = 32'd5;          d_b[8]  = 32'd0;         d_e[8]  = 32'hFFFF_FFFF;
    d_op[9]  = OP_REMU;   d_a[9]  = 32'd5;          d_b[9]  = 32'd0;         d_e[9]  = 32'd5;
    d_op[10] = OP_DIV;    d_a[10] = 32'h8000_0000;  d_b[10] = 32'hFFFF_FFFF; d_e[10] = 32'h8000_0000;
    d_op[11] = OP_REM;    d_a[11] = 32'h8000_0000;  d_b[11] = 32'hFFFF_FFFF; d_e[11] = 32'd0;
    d_op[12] = OP_DIV;    d_a[12] = 32'hFFFF_FFFB;  d_b[12] = 32'd0;         d_e[12] = 32'hFFFF_FFFF;
    d_op[13] = OP_REM;    d_a[13] = 32'hFFFF_FFFB;  d_b[13] = 32'd0;         d_e[13] = 32'hFFFF_FFFB;
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [4:0]  rr;
    last_result = 32'd0;

    // reset state
    #1;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd",     {27'd0, rd_out}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // directed cases
    for (int i = 0; i < 14; i++)
      run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i], 5'(i + 1), d_e[i]);

    // randomized cases against the reference model
    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      rr = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d_op%0d", i, rf), rf, ra, rb, rr, ref_model(rf, ra, rb));
    end

    // start while busy is ignored and its operands are not captured
    exp_q.push_back(32'd6);
    issue(OP_MUL, 32'd2, 32'd3, 5'd9);
    @(negedge clk);
    op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd10; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 1, 5'd9);

    // flush mid-CALC: no done, result held, next request completes normally
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, last_result);
    run_op("after_flush", OP_REMU, 32'd77, 32'd10, 5'd4, 32'd7);

    // test-plan MUL with rd=5, then asynchronous reset mid-CALC
    run_op("mul_rd5", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    issue(OP_MUL, 32'd11, 32'd13, 5'd6);
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy",   {31'd0, busy}, 32'd0);
    check("arst_done",   {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd",     {27'd0, rd_out}, 32'd0);
    check("arst_state",  {30'd0, dbg_state}, 32'd0);
    @(negedge clk) rst = 1'b1;
    run_op("post_rst_mul", OP_MUL, 32'd3, 32'd4, 5'd2, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Sits between the register file read ports and the register file write port.
- Takes rs1/rs2 operands (ReadData1/ReadData2) plus the destination register address, and computes over a fixed number of cycles.
- Returns a one-cycle completion pulse with result and rd that drive WriteData/WriteAddress/RegWriteEn through the writeback mux.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported; iteration count equals XLEN.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- start  input  1  request; accepted only when busy=0 and flush=0.
- op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  32  rs1 value.
- operand_b  input  32  rs2 value.
- rd_in  input  5  destination register address.
- flush  input  1  abort the in-flight operation (pipeline kill).
- busy  output  1  high from the acceptance edge until the unit returns to IDLE.
- done  output  1  one-cycle pulse; result and rd_out are valid while high.
- result  output  32  computed value.
- rd_out  output  5  rd captured at acceptance.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, rd_out=0; counter, accumulators and captured operands all 0.
- FSM states: IDLE, CALC, FIN.
  - IDLE: on start=1 & flush=0 at edge T0, capture op, operands, rd_in and sign flags; load the magnitude of signed operands; counter=0; go to CALC; busy=1.
  - CALC: one iteration per edge at T0+1..T0+32.
    - Multiply: radix-2 shift-add into a 64-bit product.
    - Divide: restoring shift-subtract giving a 32-bit quotient and remainder.
    - After the iteration with counter==31, go to FIN.
  - FIN: at edge T0+33, apply sign correction, select the output word, register result, set done=1 and busy=0, go to IDLE.
  - done falls at the next edge.
- Latency: fixed, 33 edges from acceptance to done rising, for every op including special cases; no early-out.
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - MUL returns the low 32 bits; MULH* return the high 32 bits of the 64-bit product.
- Division special cases, resolved in FIN:
  - b==0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → operand_a.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Signed remainder takes the sign of the dividend.
- start while busy=1: ignored; the request is not queued, and the issuing stage must stall on busy.
- flush:
  - In CALC or FIN: next edge goes to IDLE, busy=0, no done pulse, result/rd_out keep their previous values.
  - In IDLE: blocks acceptance of a same-cycle start.
- result and rd_out hold their last value until the next FIN.
  - rd_out==0 still pulses done; x0 suppression belongs to the writeback logic.
- done is registered on posedge; the register file writes on negedge, so WriteData is stable half a cycle before the write.
- Reset deasserted mid-operation: the unit restarts in IDLE; there is no partial completion.

Decomposition:
- Shared package riscv_pkg: XLEN, op encoding localparams (OP_MUL … OP_REMU), FSM state encoding.
- One natural sub-module: muldiv_signfix, a combinational negate/select.
  - Inputs: raw 64-bit product or quotient/remainder, sign flags, op, special-case flags.
  - Output: final 32-bit result.
- Counter, FSM and iteration datapath stay in muldiv_unit.

Test Plan:
- MUL 7 × 0xFFFFFFFD, start at edge T0 → busy high T0..T0+33; done high for exactly one cycle after T0+33; result=0xFFFFFFEB; rd_out = captured rd_in (e.g. 5).
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; each case with done at T0+33.
- Back-to-back and hazard cases:
  - Second start during busy is ignored; its operands are not captured.
  - flush at T0+10 → busy=0 at T0+11 and no done.
  - A new start at T0+12 completes normally at T0+45.
- rst=0 asserted asynchronously mid-CALC (between edges) → busy, done, result, rd_out read 0 immediately.
  - After release, a fresh MUL 3×4 → result 12.
